// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - MEM-stage RAM request to split address/data bus bridge
// One access outstanding at a time; a flush after address acceptance drains the bus quietly.
module dbus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  input  logic        flush,
  input  logic        pipeline_stall,
  output logic        stall_request,
  output logic [31:0] ram_read_data,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  logic   discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      discard       <= 1'b0;
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_wstrb     <= 4'b0;
      bus_addr      <= 32'b0;
      bus_wdata     <= 32'b0;
      ram_read_data <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_en && !flush) begin
            bus_addr  <= ram_addr;
            bus_wstrb <= ram_write_en;
            bus_wdata <= ram_write_data;
            bus_wr    <= |ram_write_en;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Once accepted the transaction must drain; before that it may be withdrawn.
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            discard <= flush;
            state   <= WAIT;
          end else if (flush) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (discard || flush) begin
              discard <= 1'b0;
              state   <= IDLE;
            end else begin
              if (!bus_wr) ram_read_data <= bus_rdata;
              state <= DONE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        DONE: begin
          // Hold here until the pipeline moves on, so a still-high ram_en is not reissued.
          if (!pipeline_stall || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_request = (state == IDLE && ram_en && !flush) ||
                         (state == REQ) || (state == WAIT);

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - scoreboard bench for dbus_bridge
// Stimulus pushes expected address phases and read data; a negedge monitor pops and compares.
module tb_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        flush;
  logic        pipeline_stall;
  logic        stall_request;
  logic [31:0] ram_read_data;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  dbus_bridge dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .flush(flush),
    .pipeline_stall(pipeline_stall), .stall_request(stall_request),
    .ram_read_data(ram_read_data), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        addr_q[$];
  logic [31:0] rd_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        mon_en = 1'b0;
  logic [31:0] prev_rd = 32'b0;
  req_t        exp_req;
  logic [31:0] exp_rd;
  int          n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_req && bus_addr_ok) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL addr_phase: got unexpected request addr %h expected none", bus_addr);
        end else begin
          exp_req = addr_q.pop_front();
          chk("mon_bus_addr", bus_addr, exp_req.addr);
          chk("mon_bus_wr", {31'b0, bus_wr}, {31'b0, exp_req.wr});
          chk("mon_bus_wstrb", {28'b0, bus_wstrb}, {28'b0, exp_req.wstrb});
          chk("mon_bus_wdata", bus_wdata, exp_req.wdata);
        end
      end
      if (ram_read_data !== prev_rd) begin
        if (rd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_data: got unexpected change to %h expected %h", ram_read_data, prev_rd);
        end else begin
          exp_rd = rd_q.pop_front();
          chk("mon_read_data", ram_read_data, exp_rd);
        end
      end
    end
    prev_rd = ram_read_data;
  end

  // Issue one access, answer the bus after aw / dw idle cycles, return the stall-cycle count.
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input int aw, input int dw, input logic [31:0] rd, output int cnt);
    cnt = 0;
    ram_en = 1'b1; ram_write_en = we; ram_addr = a; ram_write_data = wd;
    addr_q.push_back('{a, |we, we, wd});
    @(negedge clk); if (stall_request) cnt++;
    step();
    for (int i = 0; i < aw; i++) begin
      @(negedge clk); if (stall_request) cnt++;
      chk("req_held", {31'b0, bus_req}, 32'd1);
      chk("addr_held", bus_addr, a);
      step();
    end
    bus_addr_ok = 1'b1;
    @(negedge clk); if (stall_request) cnt++;
    step();
    bus_addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk); if (stall_request) cnt++;
      chk("no_req_in_wait", {31'b0, bus_req}, 32'd0);
      step();
    end
    bus_data_ok = 1'b1; bus_rdata = rd;
    if (we == 4'b0) rd_q.push_back(rd);
    @(negedge clk); if (stall_request) cnt++;
    step();
    bus_data_ok = 1'b0;
    @(negedge clk); if (stall_request) cnt++;
    chk("done_no_req", {31'b0, bus_req}, 32'd0);
  endtask

  // Leave DONE with ram_en still high: re-entering IDLE shows as a fresh stall_request.
  task automatic release_done();
    step();
    @(negedge clk);
    chk("reenter_idle", {31'b0, stall_request}, 32'd1);
    ram_en = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ram_en = 1'b0; ram_write_en = 4'b0; ram_addr = 32'b0; ram_write_data = 32'b0;
    flush = 1'b0; pipeline_stall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'b0;
    step(); step();
    @(negedge clk);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_wr", {31'b0, bus_wr}, 32'd0);
    chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_read_data", ram_read_data, 32'd0);
    chk("rst_stall", {31'b0, stall_request}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Read, bus answers immediately
    access(32'h8000_1000, 4'b0000, 32'h0, 0, 0, 32'hDEAD_BEEF, n);
    chk("read_fast_stall_cycles", n, 32'd3);
    chk("read_fast_data", ram_read_data, 32'hDEAD_BEEF);
    release_done();

    // Byte store with slow bus
    access(32'h8000_1004, 4'b0100, 32'h00AB_0000, 2, 2, 32'hFFFF_FFFF, n);
    chk("store_slow_stall_cycles", n, 32'd7);
    chk("store_keeps_read_data", ram_read_data, 32'hDEAD_BEEF);
    release_done();

    // DONE held by external stall
    access(32'h8000_2000, 4'b0000, 32'h0, 0, 0, 32'h0BAD_F00D, n);
    chk("read2_stall_cycles", n, 32'd3);
    pipeline_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("done_hold_no_req", {31'b0, bus_req}, 32'd0);
      chk("done_hold_no_stall", {31'b0, stall_request}, 32'd0);
    end
    pipeline_stall = 1'b0;
    release_done();

    // Flush before acceptance
    ram_en = 1'b1; ram_write_en = 4'b0; ram_addr = 32'h8000_3000; ram_write_data = 32'h0;
    step();
    @(negedge clk);
    chk("flush_req_raised", {31'b0, bus_req}, 32'd1);
    flush = 1'b1;
    step();
    @(negedge clk);
    chk("flush_req_withdrawn", {31'b0, bus_req}, 32'd0);
    chk("flush_no_stall", {31'b0, stall_request}, 32'd0);
    flush = 1'b0; ram_en = 1'b0;
    step();
    @(negedge clk);
    chk("flush_idle_req", {31'b0, bus_req}, 32'd0);
    chk("flush_idle_stall", {31'b0, stall_request}, 32'd0);

    // Flush after acceptance, new read waits for the drain
    ram_en = 1'b1; ram_write_en = 4'b0; ram_addr = 32'h8000_4000; ram_write_data = 32'h0;
    addr_q.push_back('{32'h8000_4000, 1'b0, 4'b0, 32'h0});
    step();
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("wait_flush_stall", {31'b0, stall_request}, 32'd1);
    step();
    flush = 1'b0; ram_addr = 32'h8000_5000;
    @(negedge clk);
    chk("drain_no_req1", {31'b0, bus_req}, 32'd0);
    chk("drain_stall", {31'b0, stall_request}, 32'd1);
    step();
    bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("drain_no_req2", {31'b0, bus_req}, 32'd0);
    step();
    bus_data_ok = 1'b0;
    access(32'h8000_5000, 4'b0000, 32'h0, 0, 0, 32'hCAFE_F00D, n);
    chk("post_flush_stall_cycles", n, 32'd3);
    chk("post_flush_data", ram_read_data, 32'hCAFE_F00D);
    release_done();

    // Reset mid-WAIT
    ram_en = 1'b1; ram_write_en = 4'b1111; ram_addr = 32'h8000_6000; ram_write_data = 32'hA5A5_A5A5;
    addr_q.push_back('{32'h8000_6000, 1'b1, 4'b1111, 32'hA5A5_A5A5});
    step();
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    rst = 1'b1;
    rd_q.push_back(32'h0);
    step();
    rst = 1'b0; ram_en = 1'b0; ram_write_en = 4'b0;
    @(negedge clk);
    chk("midrst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("midrst_bus_wr", {31'b0, bus_wr}, 32'd0);
    chk("midrst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk("midrst_bus_wdata", bus_wdata, 32'd0);
    chk("midrst_read_data", ram_read_data, 32'd0);
    chk("midrst_stall", {31'b0, stall_request}, 32'd0);
    bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
    step();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_data_ignored", ram_read_data, 32'd0);
    chk("stray_no_stall", {31'b0, stall_request}, 32'd0);

    // Recovery after reset
    access(32'h8000_7000, 4'b0000, 32'h0, 1, 1, 32'h1357_2468, n);
    chk("recover_stall_cycles", n, 32'd5);
    release_done();

    repeat (3) step();
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
